// File: rtl/fifo_stream_out.sv
// fifo_stream_out: drains a synchronous FIFO with a registered read port
// (data one cycle after a pop) onto a valid/ready stream master. A two-entry
// circular buffer plus pop credit keeps one word per cycle under any
// backpressure without loss or duplication. beats counts accepted transfers.
module fifo_stream_out #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] beats
);

  // Buffer storage and bookkeeping state
  logic [WIDTH-1:0]     buf_r [2];
  logic                 hd_r;
  logic [1:0]           occ_r;
  logic                 inflight_r;
  logic [CNT_WIDTH-1:0] beats_r;

  // Derived per-cycle signals
  logic                 pop_out_s;
  logic [2:0]           credit_s;
  logic                 rd_en_s;
  logic                 wr_idx_s;

  // Handshake, pop credit and capture slot, all from registered state
  always_comb begin
    pop_out_s = 1'b0;
    credit_s  = 3'd0;
    rd_en_s   = 1'b0;
    wr_idx_s  = 1'b0;
    pop_out_s = (occ_r != 2'd0) && m_ready;
    // Free slots not already promised to an in-flight word; a word leaving
    // this cycle frees one more, so ready rising at full occupancy has no bubble.
    credit_s  = 3'd2 - {1'b0, occ_r} - {2'b00, inflight_r} + {2'b00, pop_out_s};
    rd_en_s   = !rst && !fifo_empty && (credit_s != 3'd0);
    // Capture slot uses pre-pop head and occupancy so a buffered word is never overwritten
    wr_idx_s  = hd_r + occ_r[0];
  end

  // Stream outputs come straight from buffer state
  always_comb begin
    m_valid    = 1'b0;
    m_data     = {WIDTH{1'b0}};
    fifo_rd_en = 1'b0;
    beats      = {CNT_WIDTH{1'b0}};
    m_valid    = (occ_r != 2'd0);
    m_data     = buf_r[hd_r];
    fifo_rd_en = rd_en_s;
    beats      = beats_r;
  end

  // Buffer, head, occupancy, in-flight flag and beat counter updates
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r[0]   <= {WIDTH{1'b0}};
      buf_r[1]   <= {WIDTH{1'b0}};
      hd_r       <= 1'b0;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      beats_r    <= {CNT_WIDTH{1'b0}};
    end else begin
      inflight_r <= rd_en_s;
      if (inflight_r) begin
        buf_r[wr_idx_s] <= fifo_rd_data;
      end
      if (pop_out_s) begin
        hd_r    <= hd_r + 1'b1;
        beats_r <= beats_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      occ_r <= occ_r + {1'b0, inflight_r} - {1'b0, pop_out_s};
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Testbench for fifo_stream_out: a queue-based FIFO model feeds the DUT and a
// scoreboard of written words predicts the stream in order. Word accounting
// (popped / captured / accepted counts) predicts valid, pop and beat values.
module tb_fifo_stream_out;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 fifo_empty = 1'b1;
  logic                 fifo_rd_en;
  logic [WIDTH-1:0]     fifo_rd_data = '0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [WIDTH-1:0]     m_data;
  logic [CNT_WIDTH-1:0] beats;

  logic                 wr_en = 1'b0;
  logic [WIDTH-1:0]     wr_data = '0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] pre_q[$];
  int pops = 0;
  int captured = 0;
  int acc = 0;

  int n_checks = 0;
  int n_fail = 0;
  string tname = "";

  int first_rd, first_v, first_hs, last_hs, n_rd, n_v, n_hs, stall_rd;

  fifo_stream_out #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .beats(beats)
  );

  always #5 clk = ~clk;

  // FIFO model and word accounting: pops land one edge later; accepted words leave the scoreboard
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      exp_q.delete();
      pre_q.delete();
      pops = 0;
      captured = 0;
      acc = 0;
      fifo_rd_data <= '0;
    end else begin
      if (((captured - acc) > 0) && m_ready) begin
        acc = acc + 1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      captured = pops;
      if (fifo_rd_en && fifo_q.size() > 0) begin
        fifo_rd_data <= fifo_q.pop_front();
        pops = pops + 1;
      end
      if (wr_en) begin
        fifo_q.push_back(wr_data);
        exp_q.push_back(wr_data);
      end
      while (pre_q.size() > 0) begin
        fifo_q.push_back(pre_q[0]);
        exp_q.push_back(pre_q[0]);
        void'(pre_q.pop_front());
      end
    end
    fifo_empty <= (fifo_q.size() == 0) && !wr_en && (pre_q.size() == 0);
  end

  task automatic do_reset();
    rst = 1'b1; m_ready = 1'b0; wr_en = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) pre_q.push_back(8'(base + i));
    @(negedge clk);
  endtask

  // mode: 0 ready high, 1 low within [lo,hi], 2 alternating, 3 random
  // wr_mode: 0 none, 1 one word every 3 cycles (6 words), 2 random
  task automatic run_stream(input int n, input int mode, input int lo, input int hi, input int wr_mode);
    int outst;
    logic ev, er;
    first_rd = -1; first_v = -1; first_hs = -1; last_hs = -1;
    n_rd = 0; n_v = 0; n_hs = 0; stall_rd = 0;
    for (int c = 0; c < n; c++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = (c < lo) || (c > hi);
        2: m_ready = (c % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      wr_data = 8'($urandom);
      if (wr_mode == 1) wr_en = (c % 3 == 0) && (c < 18);
      else if (wr_mode == 2) wr_en = ($urandom_range(0, 2) == 0);
      else wr_en = 1'b0;
      #1;
      outst = pops - acc;
      ev = (captured - acc) > 0;
      er = !fifo_empty && ((outst - ((ev && m_ready) ? 1 : 0)) < 2);
      n_checks++;
      if (m_valid !== ev) begin
        n_fail++; $display("FAIL %s valid c=%0d: got %b expected %b", tname, c, m_valid, ev);
      end
      if (ev) begin
        n_checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          n_fail++; $display("FAIL %s data c=%0d: got %h expected %h", tname, c, m_data,
                             (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        end
      end
      n_checks++;
      if (fifo_rd_en !== er) begin
        n_fail++; $display("FAIL %s rd_en c=%0d: got %b expected %b", tname, c, fifo_rd_en, er);
      end
      n_checks++;
      if (outst > 2) begin
        n_fail++; $display("FAIL %s occupancy c=%0d: got %0d expected <=2", tname, c, outst);
      end
      n_checks++;
      if (beats !== 4'(acc)) begin
        n_fail++; $display("FAIL %s beats c=%0d: got %0d expected %0d", tname, c, beats, 4'(acc));
      end
      if (fifo_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = c;
        if (mode == 1 && c >= lo && c <= hi) stall_rd++;
      end
      if (m_valid) begin
        n_v++;
        if (first_v < 0) first_v = c;
        if (m_ready) begin
          n_hs++; last_hs = c;
          if (first_hs < 0) first_hs = c;
        end
      end
      @(negedge clk);
    end
    m_ready = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst = 1'b1; @(negedge clk); @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_rd_en !== 1'b0 || beats !== 4'd0) begin
      n_fail++; $display("FAIL reset: got v=%b d=%h rd=%b b=%0d expected 0 0 0 0", m_valid, m_data, fifo_rd_en, beats);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    tname = "single";
    do_reset(); preload(8'hA5, 1);
    run_stream(6, 0, 0, 0, 0);
    n_checks++;
    if (n_rd !== 1 || first_rd !== 0 || first_v !== 2 || n_v !== 1 || beats !== 4'd1) begin
      n_fail++; $display("FAIL single latency: got rd=%0d@%0d v=%0d@%0d beats=%0d expected 1@0 1@2 1",
                         n_rd, first_rd, n_v, first_v, beats);
    end
  endtask

  task automatic test_burst();
    tname = "burst";
    do_reset(); preload(8'h01, 4);
    run_stream(8, 0, 0, 0, 0);
    n_checks++;
    if (n_hs !== 4 || first_hs !== 2 || last_hs - first_hs !== 3 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL burst: got hs=%0d span %0d..%0d left=%0d expected 4 2..5 0",
                         n_hs, first_hs, last_hs, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    tname = "backpressure";
    do_reset(); preload(8'h10, 8);
    run_stream(20, 1, 3, 8, 0);
    n_checks++;
    if (stall_rd > 2 || n_hs !== 8 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL backpressure: got stall_pops=%0d hs=%0d left=%0d expected <=2 8 0",
                         stall_rd, n_hs, exp_q.size());
    end
  endtask

  task automatic test_toggle();
    tname = "toggle";
    do_reset();
    run_stream(40, 2, 0, 0, 1);
    n_checks++;
    if (n_hs !== 6 || m_valid !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL toggle: got hs=%0d valid=%b left=%0d expected 6 0 0", n_hs, m_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    tname = "reset_mid";
    do_reset(); preload(8'h20, 8);
    run_stream(6, 1, 3, 10, 0);
    m_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || beats !== 4'd0 || fifo_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got v=%b d=%h b=%0d rd=%b expected 0 0 0 0", m_valid, m_data, beats, fifo_rd_en);
    end
    rst = 1'b0; m_ready = 1'b0;
    pre_q.push_back(8'h55); pre_q.push_back(8'h66);
    @(negedge clk);
    run_stream(6, 0, 0, 0, 0);
    n_checks++;
    if (n_hs !== 2 || exp_q.size() !== 0 || beats !== 4'd2) begin
      n_fail++; $display("FAIL reset_mid restart: got hs=%0d left=%0d beats=%0d expected 2 0 2", n_hs, exp_q.size(), beats);
    end
  endtask

  task automatic test_counter_wrap();
    tname = "wrap";
    do_reset(); preload(8'h80, 17);
    run_stream(22, 0, 0, 0, 0);
    n_checks++;
    if (n_hs !== 17 || beats !== 4'd1) begin
      n_fail++; $display("FAIL wrap: got hs=%0d beats=%0d expected 17 1", n_hs, beats);
    end
  endtask

  task automatic test_random();
    tname = "random";
    do_reset();
    run_stream(400, 3, 0, 0, 2);
    run_stream(60, 0, 0, 0, 0);
    n_checks++;
    if (exp_q.size() !== 0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL random drain: got left=%0d valid=%b expected 0 0", exp_q.size(), m_valid);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_toggle();
    test_reset_mid_burst();
    test_counter_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
